axis_slave_packer: RTL

AXI4-Stream slave that terminates the 8-bit byte stream produced by the team's `axis_master`. It accepts 4-byte frames delimited by `tlast` and packs each frame into one 32-bit word presented on a valid/ready output port. It polices framing: frames with `tlast` on the wrong beat are discarded, flagged and counted. It sits at the receive end of the AXIS link, in front of register or BRAM consumers.

---
 rtl/axis_slave_packer_pkg.sv | 18 +
 rtl/axis_slave_packer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/axis_slave_packer_pkg.sv
// Shared definitions for the AXI4-Stream byte-to-word packer.
// The FSM state codes and the default frame geometry are shared with axis_master.
package axis_slave_packer_pkg;

  localparam int BYTE_W_DEF = 8;
  localparam int BEATS_DEF  = 4;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    DROP    = 2'd2
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/axis_slave_packer.sv
// Receives BEATS-byte frames from an AXI4-Stream link and presents each frame as one word.
// Frames that end early or late are discarded and counted.
//
// state   | meaning
// --------+-----------------------------------------------------------
// COLLECT | accepting beats into the partial word
// HOLD    | complete word on dout, waiting for dout_ready
// DROP    | discarding beats of an over-long frame until tlast
module axis_slave_packer
  import axis_slave_packer_pkg::*;
#(
  parameter int BYTE_W = BYTE_W_DEF,
  parameter int BEATS  = BEATS_DEF
) (
  input  logic                    s_axis_clk,
  input  logic                    s_axis_rstn,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [BYTE_W-1:0]       s_axis_tdata,
  input  logic                    s_axis_tlast,
  output logic [BYTE_W*BEATS-1:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    frame_err,
  output logic [7:0]              err_cnt
);

  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [BEATS-1:0][BYTE_W-1:0]   part_q, part_d;
  logic [BYTE_W*BEATS-1:0]        dout_q, dout_d;
  logic                           tready_q, tready_d;
  logic                           dout_valid_q, dout_valid_d;
  logic                           frame_err_q, frame_err_d;
  logic [7:0]                     err_cnt_q, err_cnt_d;
  logic                           beat_acc;

  assign beat_acc = s_axis_tvalid && tready_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    part_d       = part_q;
    dout_d       = dout_q;
    tready_d     = tready_q;
    dout_valid_d = dout_valid_q;
    frame_err_d  = 1'b0;
    err_cnt_d    = err_cnt_q;

    unique case (state_q)
      COLLECT: begin
        tready_d = 1'b1;
        if (beat_acc) begin
          idx_d = '0;
          if (idx_q != LAST_IDX) begin
            if (!s_axis_tlast) begin
              part_d[idx_q] = s_axis_tdata;
              idx_d         = idx_q + IDX_W'(1);
            end else begin
              frame_err_d = 1'b1;
              err_cnt_d   = sat_inc8(err_cnt_q);
            end
          end else if (s_axis_tlast) begin
            part_d[idx_q] = s_axis_tdata;
            dout_d        = part_d;
            dout_valid_d  = 1'b1;
            tready_d      = 1'b0;
            state_d       = HOLD;
          end else begin
            // Over-long frame: flag once here, swallow the rest in DROP.
            frame_err_d = 1'b1;
            err_cnt_d   = sat_inc8(err_cnt_q);
            state_d     = DROP;
          end
        end
      end
      HOLD: begin
        if (dout_ready) begin
          dout_valid_d = 1'b0;
          tready_d     = 1'b1;
          state_d      = COLLECT;
        end
      end
      DROP: begin
        tready_d = 1'b1;
        if (beat_acc && s_axis_tlast) begin
          state_d = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge s_axis_clk or negedge s_axis_rstn) begin
    if (!s_axis_rstn) begin
      state_q      <= COLLECT;
      idx_q        <= '0;
      part_q       <= '0;
      dout_q       <= '0;
      tready_q     <= 1'b0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      part_q       <= part_d;
      dout_q       <= dout_d;
      tready_q     <= tready_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign dout          = dout_q;
  assign dout_valid    = dout_valid_q;
  assign frame_err     = frame_err_q;
  assign err_cnt       = err_cnt_q;

endmodule
